// File: rtl/median_pkg.sv
// median_pkg: shared constants for the 3x3 median window path.
// Pixel width default, window size and window slot indices.
package median_pkg;

  localparam int PIX_W = 8;
  localparam int WIN_N = 9;
  localparam int WIN_W = WIN_N * PIX_W;

  localparam int SLOT_R0C0 = 0;
  localparam int SLOT_R0C1 = 1;
  localparam int SLOT_R0C2 = 2;
  localparam int SLOT_R1C0 = 3;
  localparam int SLOT_R1C1 = 4;
  localparam int SLOT_R1C2 = 5;
  localparam int SLOT_R2C0 = 6;
  localparam int SLOT_R2C1 = 7;
  localparam int SLOT_R2C2 = 8;

  function automatic int win_slot(
    input int r,
    input int c
  );
    return 3 * r + c;
  endfunction

endpackage

// File: rtl/median_line_buf.sv
// median_line_buf: one line of pixels, one write port, async read.
// Contents are not reset; the window generator gates stale rows.
module median_line_buf #(
  parameter int IMG_W = 640,
  parameter int PIX_W = 8
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(IMG_W)-1:0] waddr,
  input  logic [PIX_W-1:0]         wdata,
  input  logic [$clog2(IMG_W)-1:0] raddr,
  output logic [PIX_W-1:0]         rdata
);

  logic [PIX_W-1:0] mem [IMG_W];

  // store the pixel for this column on every accepted pixel
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/median_window_gen.sv
// median_window_gen: raster stream in, interior 3x3 windows out.
// Optional status ports win_count/line_done with MEDIAN_WIN_STATUS_EN.
module median_window_gen #(
  parameter int IMG_W = 640,
  parameter int PIX_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               pix_valid,
  output logic               pix_ready,
  input  logic [PIX_W-1:0]   pix_data,
  input  logic               pix_sof,
  output logic               win_valid,
  input  logic               win_ready,
  output logic [9*PIX_W-1:0] win_data
`ifdef MEDIAN_WIN_STATUS_EN
  ,
  output logic [15:0]        win_count,
  output logic               line_done
`endif
);

  import median_pkg::*;

  localparam int CW = $clog2(IMG_W);
  localparam int WW = WIN_N * PIX_W;
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [CW-1:0] COL_WIN0 = CW'(2);

  logic [CW-1:0]    col;
  logic [CW-1:0]    cur_col;
  logic [1:0]       rows_seen;
  logic [1:0]       cur_rows;
  logic             accept;
  logic             col_wrap;
  logic             produce;
  logic [PIX_W-1:0] lb0_q;
  logic [PIX_W-1:0] lb1_q;
  logic [PIX_W-1:0] sh_q [WIN_N];
  logic [PIX_W-1:0] sh_d [WIN_N];
  logic [WW-1:0]    win_next;

  assign pix_ready = !win_valid || win_ready;
  assign accept    = pix_valid && pix_ready;

  // sof forces the pixel to row 0 / col 0 wherever we were
  assign cur_col  = pix_sof ? '0 : col;
  assign cur_rows = pix_sof ? 2'd0 : rows_seen;
  assign col_wrap = (cur_col == COL_LAST);
  assign produce  = accept
                 && (cur_rows == 2'd2)
                 && (cur_col >= COL_WIN0);

  median_line_buf #(
    .IMG_W (IMG_W),
    .PIX_W (PIX_W)
  ) u_lb0 (
    .clk   (clk),
    .we    (accept),
    .waddr (cur_col),
    .wdata (lb1_q),
    .raddr (cur_col),
    .rdata (lb0_q)
  );

  median_line_buf #(
    .IMG_W (IMG_W),
    .PIX_W (PIX_W)
  ) u_lb1 (
    .clk   (clk),
    .we    (accept),
    .waddr (cur_col),
    .wdata (pix_data),
    .raddr (cur_col),
    .rdata (lb1_q)
  );

  // shift the 3x3 block left and append the new column
  always_comb begin
    for (int k = 0; k < WIN_N; k++) begin
      sh_d[k] = sh_q[k];
    end
    for (int r = 0; r < 3; r++) begin
      sh_d[win_slot(r, 0)] = sh_q[win_slot(r, 1)];
      sh_d[win_slot(r, 1)] = sh_q[win_slot(r, 2)];
    end
    sh_d[SLOT_R0C2] = lb0_q;
    sh_d[SLOT_R1C2] = lb1_q;
    sh_d[SLOT_R2C2] = pix_data;
  end

  // flatten the shifted block into the output slot order
  always_comb begin
    win_next = '0;
    for (int k = 0; k < WIN_N; k++) begin
      win_next[k*PIX_W +: PIX_W] = sh_d[k];
    end
  end

  // neighbourhood register advances once per accepted pixel
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < WIN_N; k++) begin
        sh_q[k] <= '0;
      end
    end else if (accept) begin
      for (int k = 0; k < WIN_N; k++) begin
        sh_q[k] <= sh_d[k];
      end
    end
  end

  // column counter and saturating count of completed lines
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      col       <= '0;
      rows_seen <= 2'd0;
    end else if (accept) begin
      if (col_wrap) begin
        col       <= '0;
        rows_seen <= (cur_rows == 2'd2) ? 2'd2
                                        : cur_rows + 2'd1;
      end else begin
        col       <= cur_col + CW'(1);
        rows_seen <= cur_rows;
      end
    end
  end

  // single output register; held while the consumer stalls
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      win_valid <= 1'b0;
      win_data  <= '0;
    end else if (produce) begin
      win_valid <= 1'b1;
      win_data  <= win_next;
    end else if (win_ready) begin
      win_valid <= 1'b0;
    end
  end

`ifdef MEDIAN_WIN_STATUS_EN
  // handed-over window count and end-of-line pulse
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      win_count <= '0;
      line_done <= 1'b0;
    end else begin
      line_done <= accept && col_wrap;
      if (accept && pix_sof) begin
        win_count <= '0;
      end else if (win_valid && win_ready) begin
        win_count <= win_count + 16'd1;
      end
    end
  end
`endif

endmodule
